// File: rtl/time_set_ctrl.sv
// time_set_ctrl: key-driven setting front end for the digital clock.
// Debounces the mode/select/increment buttons, runs the RUN / SET_TIME /
// SET_ALARM mode machine and edits BCD time and alarm digits with wrap.
module time_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 10000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode_n,
    input  logic       key_sel_n,
    input  logic       key_inc_n,
    input  logic [3:0] cur_hour_shi,
    input  logic [3:0] cur_hour_ge,
    input  logic [3:0] cur_min_shi,
    input  logic [3:0] cur_min_ge,
    input  logic [3:0] cur_sec_shi,
    input  logic [3:0] cur_sec_ge,
    output logic [3:0] set_hour_shi,
    output logic [3:0] set_hour_ge,
    output logic [3:0] set_min_shi,
    output logic [3:0] set_min_ge,
    output logic [3:0] set_sec_shi,
    output logic [3:0] set_sec_ge,
    output logic       set_time_finish,
    output logic [3:0] clock_hour_shi,
    output logic [3:0] clock_hour_ge,
    output logic [3:0] clock_min_shi,
    output logic [3:0] clock_min_ge,
    output logic       clock_en,
    output logic [1:0] mode,
    output logic [1:0] field
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_SET_TIME  = 2'd1,
        ST_SET_ALARM = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Key index: 0 = mode, 1 = sel, 2 = inc
    logic [2:0]       w_key_raw;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_stable;
    logic [2:0]       r_evt;
    logic [CNT_W-1:0] r_cnt [3];

    logic w_ev_mode;
    logic w_ev_sel;
    logic w_ev_inc;

    state_t      r_state, w_nxt_state;
    logic [1:0]  r_field, w_nxt_field;
    logic [23:0] r_set,   w_nxt_set;     // {hour_shi,hour_ge,min_shi,min_ge,sec_shi,sec_ge}
    logic [15:0] r_clk,   w_nxt_clk;     // {hour_shi,hour_ge,min_shi,min_ge}
    logic        r_clk_en, w_nxt_clk_en;
    logic        r_finish, w_nxt_finish;

    assign w_key_raw = {key_inc_n, key_sel_n, key_mode_n};

    // Hour increment: 09->10, 19->20, 23->00; any out-of-range value wraps to 00
    function automatic logic [7:0] inc_hour(input logic [7:0] v);
        logic [3:0] shi;
        logic [3:0] ge;
        shi = v[7:4];
        ge  = v[3:0];
        if (shi > 4'd2 || ge > 4'd9 || (shi == 4'd2 && ge >= 4'd3))
            return 8'h00;
        else if (ge == 4'd9)
            return {shi + 4'd1, 4'd0};
        else
            return {shi, ge + 4'd1};
    endfunction

    // Minute/second increment: x9 carries into tens, 59->00; out-of-range wraps to 00
    function automatic logic [7:0] inc_ms(input logic [7:0] v);
        logic [3:0] shi;
        logic [3:0] ge;
        shi = v[7:4];
        ge  = v[3:0];
        if (shi > 4'd5 || ge > 4'd9)
            return 8'h00;
        else if (ge == 4'd9)
            return (shi == 4'd5) ? 8'h00 : {shi + 4'd1, 4'd0};
        else
            return {shi, ge + 4'd1};
    endfunction

    // Per-key synchronizer, stability counter and press-event register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_stable <= '1;
            r_evt    <= '0;
            for (int unsigned k = 0; k < 3; k++)
                r_cnt[k] <= '0;
        end else begin
            r_sync1 <= w_key_raw;
            r_sync2 <= r_sync1;
            r_evt   <= '0;
            for (int unsigned k = 0; k < 3; k++) begin
                if (r_sync2[k] == r_stable[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == LP_CNT_MAX) begin
                    r_stable[k] <= r_sync2[k];
                    r_cnt[k]    <= '0;
                    r_evt[k]    <= ~r_sync2[k];
                end else begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end
            end
        end
    end

    // Same-cycle priority: mode beats sel beats inc
    assign w_ev_mode = r_evt[0];
    assign w_ev_sel  = r_evt[1] & ~r_evt[0];
    assign w_ev_inc  = r_evt[2] & ~r_evt[1] & ~r_evt[0];

    // State and edited-digit registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_field  <= '0;
            r_set    <= '0;
            r_clk    <= '0;
            r_clk_en <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_field  <= w_nxt_field;
            r_set    <= w_nxt_set;
            r_clk    <= w_nxt_clk;
            r_clk_en <= w_nxt_clk_en;
            r_finish <= w_nxt_finish;
        end
    end

    // Mode transitions, field selection and digit editing
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_field  = r_field;
        w_nxt_set    = r_set;
        w_nxt_clk    = r_clk;
        w_nxt_clk_en = r_clk_en;
        w_nxt_finish = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_ev_mode) begin
                    w_nxt_state = ST_SET_TIME;
                    w_nxt_field = 2'd0;
                    w_nxt_set   = {cur_hour_shi, cur_hour_ge, cur_min_shi,
                                   cur_min_ge, cur_sec_shi, cur_sec_ge};
                end else if (w_ev_sel) begin
                    w_nxt_clk_en = ~r_clk_en;
                end
            end
            ST_SET_TIME: begin
                if (w_ev_mode) begin
                    w_nxt_state  = ST_SET_ALARM;
                    w_nxt_field  = 2'd0;
                    w_nxt_finish = 1'b1;
                end else if (w_ev_sel) begin
                    w_nxt_field = (r_field >= 2'd2) ? 2'd0 : r_field + 2'd1;
                end else if (w_ev_inc) begin
                    case (r_field)
                        2'd0:    w_nxt_set[23:16] = inc_hour(r_set[23:16]);
                        2'd1:    w_nxt_set[15:8]  = inc_ms(r_set[15:8]);
                        2'd2:    w_nxt_set[7:0]   = inc_ms(r_set[7:0]);
                        default: w_nxt_set        = r_set;
                    endcase
                end
            end
            ST_SET_ALARM: begin
                if (w_ev_mode) begin
                    w_nxt_state = ST_RUN;
                    w_nxt_field = 2'd0;
                end else if (w_ev_sel) begin
                    w_nxt_field = (r_field == 2'd0) ? 2'd1 : 2'd0;
                end else if (w_ev_inc) begin
                    case (r_field)
                        2'd0:    w_nxt_clk[15:8] = inc_hour(r_clk[15:8]);
                        2'd1:    w_nxt_clk[7:0]  = inc_ms(r_clk[7:0]);
                        default: w_nxt_clk       = r_clk;
                    endcase
                end
            end
            default: begin
                w_nxt_state = ST_RUN;
                w_nxt_field = 2'd0;
            end
        endcase
    end

    assign {set_hour_shi, set_hour_ge, set_min_shi, set_min_ge,
            set_sec_shi, set_sec_ge}                     = r_set;
    assign {clock_hour_shi, clock_hour_ge, clock_min_shi,
            clock_min_ge}                                = r_clk;
    assign set_time_finish = r_finish;
    assign clock_en        = r_clk_en;
    assign mode            = r_state;
    assign field           = r_field;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed testbench for time_set_ctrl with a short debounce window.
module tb_time_set_ctrl;

    logic       clk;
    logic       rst_n;
    logic       key_mode_n, key_sel_n, key_inc_n;
    logic [3:0] cur_hour_shi, cur_hour_ge, cur_min_shi, cur_min_ge, cur_sec_shi, cur_sec_ge;
    logic [3:0] set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge;
    logic       set_time_finish;
    logic [3:0] clock_hour_shi, clock_hour_ge, clock_min_shi, clock_min_ge;
    logic       clock_en;
    logic [1:0] mode;
    logic [1:0] field;

    int errors = 0;
    int checks = 0;
    int fin_cnt = 0;
    int fin_snap;

    time_set_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_mode_n(key_mode_n), .key_sel_n(key_sel_n), .key_inc_n(key_inc_n),
        .cur_hour_shi(cur_hour_shi), .cur_hour_ge(cur_hour_ge),
        .cur_min_shi(cur_min_shi), .cur_min_ge(cur_min_ge),
        .cur_sec_shi(cur_sec_shi), .cur_sec_ge(cur_sec_ge),
        .set_hour_shi(set_hour_shi), .set_hour_ge(set_hour_ge),
        .set_min_shi(set_min_shi), .set_min_ge(set_min_ge),
        .set_sec_shi(set_sec_shi), .set_sec_ge(set_sec_ge),
        .set_time_finish(set_time_finish),
        .clock_hour_shi(clock_hour_shi), .clock_hour_ge(clock_hour_ge),
        .clock_min_shi(clock_min_shi), .clock_min_ge(clock_min_ge),
        .clock_en(clock_en), .mode(mode), .field(field)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of cycles the finish strobe is high, sampled mid-cycle
    always @(negedge clk) if (set_time_finish === 1'b1) fin_cnt++;

    function automatic logic [23:0] set_vec();
        return {set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge};
    endfunction

    function automatic logic [15:0] clk_vec();
        return {clock_hour_shi, clock_hour_ge, clock_min_shi, clock_min_ge};
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_cur(input logic [23:0] v);
        {cur_hour_shi, cur_hour_ge, cur_min_shi, cur_min_ge, cur_sec_shi, cur_sec_ge} = v;
    endtask

    // Clean press of any combination of keys, long enough to pass debounce both ways
    task automatic press(input logic m, input logic s, input logic i);
        key_mode_n = ~m;
        key_sel_n  = ~s;
        key_inc_n  = ~i;
        cycles(12);
        key_mode_n = 1'b1;
        key_sel_n  = 1'b1;
        key_inc_n  = 1'b1;
        cycles(12);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycles(3);
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL reset_mode got=%0d exp=0", mode); end
        checks++; if (field !== 2'd0) begin errors++; $display("FAIL reset_field got=%0d exp=0", field); end
        checks++; if (set_vec() !== 24'h000000) begin errors++; $display("FAIL reset_set got=%h exp=000000", set_vec()); end
        checks++; if (clk_vec() !== 16'h0000) begin errors++; $display("FAIL reset_clock got=%h exp=0000", clk_vec()); end
        checks++; if (clock_en !== 1'b0) begin errors++; $display("FAIL reset_clock_en got=%b exp=0", clock_en); end
        checks++; if (set_time_finish !== 1'b0) begin errors++; $display("FAIL reset_finish got=%b exp=0", set_time_finish); end
        rst_n = 1'b1;
        cycles(3);
    endtask

    task automatic test_time_load();
        set_cur(24'h123456);
        press(1'b1, 1'b0, 1'b0);
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL load_mode got=%0d exp=1", mode); end
        checks++; if (set_vec() !== 24'h123456) begin errors++; $display("FAIL load_copy got=%h exp=123456", set_vec()); end
        press(1'b0, 1'b1, 1'b0);
        checks++; if (field !== 2'd1) begin errors++; $display("FAIL load_field got=%0d exp=1", field); end
        repeat (3) press(1'b0, 1'b0, 1'b1);
        checks++; if (set_vec() !== 24'h123756) begin errors++; $display("FAIL load_inc got=%h exp=123756", set_vec()); end
        fin_snap = fin_cnt;
        press(1'b1, 1'b0, 1'b0);
        checks++; if (fin_cnt - fin_snap !== 1) begin errors++; $display("FAIL load_finish_cycles got=%0d exp=1", fin_cnt - fin_snap); end
        checks++; if (mode !== 2'd2) begin errors++; $display("FAIL load_mode_alarm got=%0d exp=2", mode); end
        checks++; if (field !== 2'd0) begin errors++; $display("FAIL load_field_reset got=%0d exp=0", field); end
        checks++; if (set_vec() !== 24'h123756) begin errors++; $display("FAIL load_hold got=%h exp=123756", set_vec()); end
    endtask

    task automatic test_alarm_edit();
        fin_snap = fin_cnt;
        repeat (7) press(1'b0, 1'b0, 1'b1);
        checks++; if (clk_vec() !== 16'h0700) begin errors++; $display("FAIL alarm_hour got=%h exp=0700", clk_vec()); end
        press(1'b0, 1'b1, 1'b0);
        checks++; if (field !== 2'd1) begin errors++; $display("FAIL alarm_field1 got=%0d exp=1", field); end
        repeat (61) press(1'b0, 1'b0, 1'b1);
        checks++; if (clk_vec() !== 16'h0701) begin errors++; $display("FAIL alarm_min got=%h exp=0701", clk_vec()); end
        checks++; if (set_vec() !== 24'h123756) begin errors++; $display("FAIL alarm_set_untouched got=%h exp=123756", set_vec()); end
        press(1'b0, 1'b1, 1'b0);
        checks++; if (field !== 2'd0) begin errors++; $display("FAIL alarm_field0 got=%0d exp=0", field); end
        press(1'b1, 1'b0, 1'b0);
        checks++; if (mode !== 2'd0) begin errors++; $display("FAIL alarm_to_run got=%0d exp=0", mode); end
        checks++; if (fin_cnt !== fin_snap) begin errors++; $display("FAIL alarm_no_finish got=%0d exp=%0d", fin_cnt, fin_snap); end
        checks++; if (clock_en !== 1'b0) begin errors++; $display("FAIL alarm_en_kept got=%b exp=0", clock_en); end
    endtask

    task automatic test_clock_en();
        press(1'b0, 1'b1, 1'b0);
        checks++; if (clock_en !== 1'b1) begin errors++; $display("FAIL en_toggle1 got=%b exp=1", clock_en); end
        press(1'b0, 1'b1, 1'b0);
        checks++; if (clock_en !== 1'b0) begin errors++; $display("FAIL en_toggle0 got=%b exp=0", clock_en); end
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        checks++; if (clock_en !== 1'b1 || mode !== 2'd0) begin errors++; $display("FAIL en_inc_ignored got=%b/%0d exp=1/0", clock_en, mode); end
        set_cur(24'h234517);
        press(1'b1, 1'b1, 1'b0);
        checks++; if (mode !== 2'd1) begin errors++; $display("FAIL en_simul_mode got=%0d exp=1", mode); end
        checks++; if (clock_en !== 1'b1) begin errors++; $display("FAIL en_simul_unchanged got=%b exp=1", clock_en); end
        checks++; if (field !== 2'd0) begin errors++; $display("FAIL en_simul_field got=%0d exp=0", field); end
        checks++; if (set_vec() !== 24'h234517) begin errors++; $display("FAIL en_simul_copy got=%h exp=234517", set_vec()); end
    endtask

    task automatic test_hour_wrap();
        press(1'b0, 1'b0, 1'b1);
        checks++; if (set_vec() !== 24'h004517) begin errors++; $display("FAIL wrap_23 got=%h exp=004517", set_vec()); end
        repeat (9) press(1'b0, 1'b0, 1'b1);
        checks++; if (set_vec() !== 24'h094517) begin errors++; $display("FAIL wrap_09 got=%h exp=094517", set_vec()); end
        press(1'b0, 1'b0, 1'b1);
        checks++; if (set_vec() !== 24'h104517) begin errors++; $display("FAIL wrap_10 got=%h exp=104517", set_vec()); end
        checks++; if (clk_vec() !== 16'h0701) begin errors++; $display("FAIL wrap_alarm_kept got=%h exp=0701", clk_vec()); end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) begin
            key_inc_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            cycles(2);
        end
        key_inc_n = 1'b0;
        cycles(12);
        key_inc_n = 1'b1;
        cycles(12);
        checks++; if (set_vec() !== 24'h114517) begin errors++; $display("FAIL bounce_one_event got=%h exp=114517", set_vec()); end
        key_inc_n = 1'b0;
        cycles(3);
        key_inc_n = 1'b1;
        cycles(15);
        checks++; if (set_vec() !== 24'h114517) begin errors++; $display("FAIL glitch_rejected got=%h exp=114517", set_vec()); end
    endtask

    task automatic test_reset_mid_edit();
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        checks++; if (set_vec() !== 24'h114617) begin errors++; $display("FAIL mid_edit_pre got=%h exp=114617", set_vec()); end
        fin_snap = fin_cnt;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checks++; if (mode !== 2'd0 || field !== 2'd0) begin errors++; $display("FAIL mid_reset_mode got=%0d/%0d exp=0/0", mode, field); end
        checks++; if (set_vec() !== 24'h000000 || clk_vec() !== 16'h0000 || clock_en !== 1'b0) begin
            errors++; $display("FAIL mid_reset_regs got=%h/%h/%b exp=000000/0000/0", set_vec(), clk_vec(), clock_en);
        end
        cycles(3);
        rst_n = 1'b1;
        cycles(5);
        checks++; if (fin_cnt !== fin_snap) begin errors++; $display("FAIL mid_reset_no_finish got=%0d exp=%0d", fin_cnt, fin_snap); end
    endtask

    task automatic test_out_of_range();
        set_cur(24'h253917);
        press(1'b1, 1'b0, 1'b0);
        checks++; if (set_vec() !== 24'h253917) begin errors++; $display("FAIL oor_copy got=%h exp=253917", set_vec()); end
        press(1'b0, 1'b0, 1'b1);
        checks++; if (set_vec() !== 24'h003917) begin errors++; $display("FAIL oor_wrap got=%h exp=003917", set_vec()); end
    endtask

    initial begin
        rst_n      = 1'b0;
        key_mode_n = 1'b1;
        key_sel_n  = 1'b1;
        key_inc_n  = 1'b1;
        set_cur(24'h000000);
        test_reset();
        test_time_load();
        test_alarm_edit();
        test_clock_en();
        test_hour_wrap();
        test_bounce();
        test_reset_mid_edit();
        test_out_of_range();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Key-driven setting front end for the digital clock.
- Debounces three raw push-buttons and runs a mode FSM (RUN / SET_TIME / SET_ALARM).
- Edits BCD hour/minute/second digits with wrap. Emits the load-time digit bus plus a one-cycle set_time_finish strobe, the alarm digits and the alarm enable.
- Sits directly upstream of the timekeeping/alarm block and feeds its set_*, clock_* and clock_en inputs. The current time is read back from that block's *_r outputs.

Parameters:
- DEBOUNCE_CYCLES, 10000: clk cycles a synchronized key level must stay stable before it is accepted. At a 500 kHz clk this is 20 ms. Minimum 2.
- CNT_W, 16: width of the debounce counter. Must hold DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_mode_n  in  1  raw mode button, active-low, asynchronous to clk
- key_sel_n  in  1  raw field-select button, active-low
- key_inc_n  in  1  raw increment button, active-low
- cur_hour_shi, cur_hour_ge, cur_min_shi, cur_min_ge, cur_sec_shi, cur_sec_ge  in  4 each  running time, BCD
- set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge  out  4 each  time being edited, BCD
- set_time_finish  out  1  one-cycle load strobe
- clock_hour_shi, clock_hour_ge, clock_min_shi, clock_min_ge  out  4 each  alarm time, BCD
- clock_en  out  1  alarm enable
- mode  out  2  0=RUN, 1=SET_TIME, 2=SET_ALARM
- field  out  2  selected field: 0=hour, 1=min, 2=sec

Behaviour:
- Reset values: mode=RUN, field=0, all set_* = 0, all clock_* = 0, clock_en=0, set_time_finish=0, debounce state = released (1).
- Clock and reset: single clock; reset is asynchronous, active-low, named rst_n; clk named clk. All state is in the clk domain.
- Debounce, per key:
  - 2-FF synchronizer.
  - Counter restarts whenever the synchronized level differs from the accepted level.
  - The accepted level updates when the counter reaches DEBOUNCE_CYCLES-1.
  - A press event is a 1-cycle pulse on an accepted 1->0 transition. Release generates no event.
  - Holding a key gives exactly one event (no auto-repeat).
  - Latency from raw edge to event: 2 sync cycles + DEBOUNCE_CYCLES + 1 register.
- Event priority within one cycle: mode > sel > inc. Lower-priority events in the same cycle are discarded.
- FSM on the mode event:
  - RUN->SET_TIME: copy cur_* into set_* in the same edge; field=0.
  - SET_TIME->SET_ALARM: set_time_finish=1 for exactly the next cycle; field=0.
  - SET_ALARM->RUN: field=0.
  - mode=3 is unreachable; if it occurs, go to RUN.
- sel event:
  - SET_TIME: field cycles 0->1->2->0.
  - SET_ALARM: field cycles 0->1->0.
  - RUN: toggles clock_en.
- inc event (RUN: ignored):
  - SET_TIME edits the set_* field selected by field.
  - SET_ALARM edits the clock_* field selected by field.
  - Hour: 09->10, 19->20, 23->00.
  - Min/sec: ge 9->0 with shi+1; 59->00.
  - Editing a field never changes any other field.
- set_* hold their value outside SET_TIME. set_time_finish is asserted only on the SET_TIME->SET_ALARM transition.
- Out-of-range cur_* inputs are copied verbatim. The next inc on that field wraps it to 00.
- Reset mid-edit: everything returns to reset values and no finish strobe is issued.
- The alarm digits and clock_en change only through their own edits or toggles, or through reset.

Test Plan (DEBOUNCE_CYCLES=4):
- Bounce rejection: key_inc_n toggles every 2 cycles for 20 cycles, then holds low -> exactly one inc event. A 3-cycle low glitch -> no event.
- Time load: cur=12:34:56; mode press, sel, inc x3, mode -> set_*=12:37:56, set_time_finish high exactly 1 cycle, mode=2.
- Hour wrap: in SET_TIME with hour=23, inc -> 00. With hour=09, inc -> 10. Minute/second digits unchanged.
- Alarm edit: in SET_ALARM, hour inc x7, sel, min inc x61 -> clock=07:01, field back to 0 after a second sel. Third mode press -> RUN with no set_time_finish.
- clock_en: sel press in RUN toggles 0->1->0. Simultaneous mode+sel in RUN -> enters SET_TIME and clock_en is unchanged.
- Reset mid-edit: assert rst_n low in SET_TIME after edits -> all outputs return to 0 and mode=RUN. set_time_finish is never asserted.
